// File: rtl/pdp11_operand_fetch.sv
// rtl/pdp11_operand_fetch.sv - PDP-11 addressing-mode operand fetch sequencer
// Resolves one mode/register specifier into operand, effective address and register writeback.
module pdp11_operand_fetch #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int NUM_REGS  = 8,
  parameter int WORD_STEP = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [2:0]                  mode,
  input  logic [$clog2(NUM_REGS)-1:0] reg_sel,
  input  logic                        byte_op,
  output logic                        busy,
  output logic [$clog2(NUM_REGS)-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]           rf_rd_data,
  output logic                        rf_wr_en,
  output logic [$clog2(NUM_REGS)-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]           rf_wr_data,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        done,
  output logic                        err,
  output logic [DATA_W-1:0]           operand,
  output logic [ADDR_W-1:0]           ea,
  output logic                        ea_valid
);
  localparam int RW = $clog2(NUM_REGS);
  localparam logic [RW-1:0]     SP_IDX = RW'(NUM_REGS - 2);
  localparam logic [RW-1:0]     PC_IDX = RW'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] WSTEP  = ADDR_W'(WORD_STEP);

  // S_REG is the register-read cycle that follows start; it owns the Rn writeback.
  typedef enum logic [2:0] {S_IDLE, S_REG, S_INDEX, S_DEFER, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        mode_q, mode_d;
  logic [RW-1:0]     reg_q, reg_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] rn_q, rn_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic              ea_valid_q, ea_valid_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] step, rd_a, pc_next;
  logic              fault;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    reg_d      = reg_q;
    byte_d     = byte_q;
    rn_d       = rn_q;
    ptr_d      = ptr_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    operand_d  = operand_q;
    ea_d       = ea_q;
    ea_valid_d = ea_valid_q;
    err_d      = err_q;
    fault      = 1'b0;
    rf_rd_addr = reg_q;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    rd_a       = ADDR_W'(rf_rd_data);
    pc_next    = mem_addr_q + WSTEP;
    step = (byte_q && (reg_q < SP_IDX) && (mode_q != 3'd3) && (mode_q != 3'd5))
           ? ADDR_W'(1) : WSTEP;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          reg_d   = reg_sel;
          byte_d  = byte_op;
          err_d   = 1'b0;
          state_d = S_REG;
        end
      end
      S_REG: begin
        rn_d = rd_a;
        case (mode_q)
          3'd0: begin
            operand_d  = byte_q ? DATA_W'(rf_rd_data[7:0]) : rf_rd_data;
            ea_d       = '0;
            ea_valid_d = 1'b0;
            state_d    = S_DONE;
          end
          3'd1: begin
            ptr_d   = rd_a;
            state_d = S_DATA;
          end
          3'd2, 3'd3: begin
            ptr_d      = rd_a;
            rf_wr_en   = 1'b1;
            rf_wr_addr = reg_q;
            rf_wr_data = DATA_W'(rd_a + step);
            state_d    = mode_q[0] ? S_DEFER : S_DATA;
          end
          3'd4, 3'd5: begin
            ptr_d      = rd_a - step;
            rf_wr_en   = 1'b1;
            rf_wr_addr = reg_q;
            rf_wr_data = DATA_W'(rd_a - step);
            state_d    = mode_q[0] ? S_DEFER : S_DATA;
          end
          default: state_d = S_INDEX;
        endcase
      end
      S_INDEX: begin
        rf_rd_addr = PC_IDX;
        if (!mem_req_q) begin
          if (rd_a[0]) fault = 1'b1;
          else begin
            mem_req_d  = 1'b1;
            mem_addr_d = rd_a;
          end
        end else if (mem_ack) begin
          // An index off the PC itself is relative to the already-advanced PC.
          mem_req_d  = 1'b0;
          rf_wr_en   = 1'b1;
          rf_wr_addr = PC_IDX;
          rf_wr_data = DATA_W'(pc_next);
          ptr_d      = ADDR_W'(mem_rdata) + ((reg_q == PC_IDX) ? pc_next : rn_q);
          state_d    = mode_q[0] ? S_DEFER : S_DATA;
        end
      end
      S_DEFER: begin
        if (!mem_req_q) begin
          if (ptr_q[0]) fault = 1'b1;
          else begin
            mem_req_d  = 1'b1;
            mem_addr_d = ptr_q;
          end
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          ptr_d     = ADDR_W'(mem_rdata);
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (!mem_req_q) begin
          if (!byte_q && ptr_q[0]) fault = 1'b1;
          else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {ptr_q[ADDR_W-1:1], 1'b0};
          end
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!byte_q)       operand_d = mem_rdata;
          else if (ptr_q[0]) operand_d = DATA_W'(mem_rdata[15:8]);
          else               operand_d = DATA_W'(mem_rdata[7:0]);
          ea_d       = ptr_q;
          ea_valid_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fault) begin
      err_d      = 1'b1;
      ea_valid_d = 1'b0;
      state_d    = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      reg_q      <= '0;
      byte_q     <= 1'b0;
      rn_q       <= '0;
      ptr_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      operand_q  <= '0;
      ea_q       <= '0;
      ea_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      reg_q      <= reg_d;
      byte_q     <= byte_d;
      rn_q       <= rn_d;
      ptr_q      <= ptr_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      operand_q  <= operand_d;
      ea_q       <= ea_d;
      ea_valid_q <= ea_valid_d;
      err_q      <= err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign operand  = operand_q;
  assign ea       = ea_q;
  assign ea_valid = ea_valid_q;

endmodule

// File: tb/tb_pdp11_operand_fetch.sv
// tb/tb_pdp11_operand_fetch.sv - randomized self-checking bench for pdp11_operand_fetch
// Register file and memory are bench models; expected results come from a per-mode reference.
module tb_pdp11_operand_fetch;
  logic        clk = 1'b0;
  logic        rst_n, start, byte_op;
  logic [2:0]  mode, reg_sel, rf_rd_addr, rf_wr_addr;
  logic [15:0] rf_rd_data, rf_wr_data, mem_addr, mem_rdata, operand, ea;
  logic        busy, rf_wr_en, mem_req, done, err, ea_valid;
  logic        mem_ack = 1'b0;

  int nchk = 0;
  int nerr = 0;

  logic [15:0] regs  [8];
  logic [15:0] sregs [8];
  logic        load_all;
  logic [15:0] mem [logic [15:0]];
  int          wait_cfg;
  int          wcnt = 0;
  logic        spurious;
  logic [18:0] wr_q [$];
  int          req_cnt = 0;
  int          stab_cnt = 0;
  logic        req_prev = 1'b0;
  logic [15:0] addr_prev = 16'h0;

  always #5 clk = ~clk;

  pdp11_operand_fetch dut (
    .clk(clk), .reset_n(rst_n), .start(start), .mode(mode), .reg_sel(reg_sel),
    .byte_op(byte_op), .busy(busy), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .err(err), .operand(operand), .ea(ea), .ea_valid(ea_valid)
  );

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA5A4;
  endfunction

  assign rf_rd_data = regs[rf_rd_addr];

  always @(posedge clk) begin
    if (load_all) regs <= sregs;
    else if (rf_wr_en) regs[rf_wr_addr] <= rf_wr_data;
  end

  always @(posedge clk) begin
    if (rf_wr_en) wr_q.push_back({rf_wr_addr, rf_wr_data});
    req_prev  <= mem_req;
    addr_prev <= mem_addr;
    if (mem_req && !req_prev) req_cnt <= req_cnt + 1;
    if (mem_req && req_prev && mem_addr != addr_prev) stab_cnt <= stab_cnt + 1;
  end

  always @(negedge clk) begin
    if (!mem_req) begin
      wcnt      <= 0;
      mem_ack   <= spurious && ($urandom_range(0, 1) == 1);
      mem_rdata <= 16'($urandom);
    end else if (wcnt >= wait_cfg) begin
      mem_ack   <= 1'b1;
      mem_rdata <= mem_rd(mem_addr);
    end else begin
      mem_ack   <= 1'b0;
      wcnt      <= wcnt + 1;
      mem_rdata <= 16'($urandom);
    end
  end

  // Reference: walks the addressing-mode rules directly on the shadow register file.
  task automatic model(input logic [2:0] m, input logic [2:0] r, input logic b, input int w,
                       output logic [15:0] op, output logic [15:0] e_ea, output logic ev,
                       output logic er, output int lat, output int nreq,
                       output logic wv, output logic [2:0] wa, output logic [15:0] wd);
    logic [15:0] rv, ptr, pc2, wrd, step;
    logic flt;
    rv = sregs[r];
    step = (b && r < 3'd6 && m != 3'd3 && m != 3'd5) ? 16'd1 : 16'd2;
    op = 16'h0; e_ea = 16'h0; ev = 1'b0; nreq = 0; wv = 1'b0; wa = 3'd0; wd = 16'h0;
    flt = 1'b0; ptr = 16'h0;
    case (m)
      3'd0: op = b ? {8'h00, rv[7:0]} : rv;
      3'd1: ptr = rv;
      3'd2, 3'd3: begin ptr = rv; wv = 1'b1; wa = r; wd = rv + step; end
      3'd4, 3'd5: begin ptr = rv - step; wv = 1'b1; wa = r; wd = ptr; end
      default: begin
        if (sregs[7][0]) flt = 1'b1;
        else begin
          pc2 = sregs[7] + 16'd2;
          nreq++; wv = 1'b1; wa = 3'd7; wd = pc2;
          ptr = mem_rd(sregs[7]) + ((r == 3'd7) ? pc2 : rv);
        end
      end
    endcase
    if (!flt && m[0] && m != 3'd1) begin
      if (ptr[0]) flt = 1'b1;
      else begin ptr = mem_rd(ptr); nreq++; end
    end
    if (!flt && m != 3'd0) begin
      if (!b && ptr[0]) flt = 1'b1;
      else begin
        wrd = mem_rd({ptr[15:1], 1'b0});
        op = !b ? wrd : (ptr[0] ? {8'h00, wrd[15:8]} : {8'h00, wrd[7:0]});
        e_ea = ptr; ev = 1'b1; nreq++;
      end
    end
    er = flt;
    lat = 2 + nreq * (2 + w) + (flt ? 1 : 0);
  endtask

  task automatic load_regs;
    @(negedge clk); load_all = 1'b1;
    @(posedge clk); #1 load_all = 1'b0;
  endtask

  task automatic do_req(input logic [2:0] m, input logic [2:0] r, input logic b, input int w,
                        input logic inject, output logic [15:0] o_op, output logic [15:0] o_ea,
                        output logic o_ev, output logic o_err, output int o_lat,
                        output int o_nreq, output logic [18:0] o_wr);
    logic [15:0] e_op, e_ea, wd;
    logic e_ev, e_er, wv;
    logic [2:0] wa;
    int e_lat, e_nreq, n0, r0, s0, cyc;
    bit got;
    o_op = 16'h0; o_ea = 16'h0; o_ev = 1'b0; o_err = 1'b0; o_lat = 0; o_nreq = 0; o_wr = '1;
    load_regs();
    model(m, r, b, w, e_op, e_ea, e_ev, e_er, e_lat, e_nreq, wv, wa, wd);
    n0 = wr_q.size(); r0 = req_cnt; s0 = stab_cnt; wait_cfg = w;
    @(negedge clk); start = 1'b1; mode = m; reg_sel = r; byte_op = b;
    @(posedge clk); #1 start = 1'b0;
    mode = 3'($urandom); reg_sel = 3'($urandom); byte_op = 1'($urandom);
    cyc = 0; got = 0;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        if (inject && cyc == 1) begin start = 1'b1; mode = 3'd0; reg_sel = 3'd0; byte_op = 1'b0; end
        @(posedge clk); #1 start = 1'b0; cyc++;
      end
    end
    nchk++;
    if (!got) begin
      nerr++; $display("FAIL done_timeout m=%0d r=%0d got no done want done", m, r);
      return;
    end
    o_lat = cyc + 1; o_op = operand; o_ea = ea; o_ev = ea_valid; o_err = err;
    o_nreq = req_cnt - r0;
    nchk++;
    if (o_lat !== e_lat) begin nerr++; $display("FAIL latency m=%0d got %0d want %0d", m, o_lat, e_lat); end
    nchk++;
    if (o_err !== e_er) begin nerr++; $display("FAIL err m=%0d got %0b want %0b", m, o_err, e_er); end
    nchk++;
    if (o_nreq !== e_nreq) begin nerr++; $display("FAIL mem_req_count m=%0d got %0d want %0d", m, o_nreq, e_nreq); end
    if (!e_er) begin
      nchk++;
      if (o_op !== e_op || o_ea !== e_ea || o_ev !== e_ev) begin
        nerr++;
        $display("FAIL result m=%0d r=%0d b=%0b got op=%h ea=%h ev=%0b want op=%h ea=%h ev=%0b",
                 m, r, b, o_op, o_ea, o_ev, e_op, e_ea, e_ev);
      end
    end
    @(negedge clk);
    nchk++;
    if (done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL idle_after got done=%0b busy=%0b want 0 0", done, busy); end
    nchk++;
    if (wr_q.size() - n0 != int'(wv)) begin
      nerr++; $display("FAIL wb_count m=%0d got %0d want %0d", m, wr_q.size() - n0, wv);
    end else if (wv) begin
      o_wr = wr_q[wr_q.size() - 1];
      if (o_wr !== {wa, wd}) begin nerr++; $display("FAIL wb_value m=%0d got %h want %h", m, o_wr, {wa, wd}); end
    end
    nchk++;
    if (stab_cnt !== s0) begin nerr++; $display("FAIL addr_stable got %0d changes want 0", stab_cnt - s0); end
    if (wv) sregs[wa] = wd;
  endtask

  logic [15:0] t_op, t_ea;
  logic        t_ev, t_err;
  int          t_lat, t_nreq;
  logic [18:0] t_wr;

  task automatic test_reset;
    repeat (3) @(negedge clk);
    nchk++;
    if ({busy, mem_req, rf_wr_en, done, err, ea_valid} !== 6'b0) begin
      nerr++; $display("FAIL reset_flags got %b want 000000", {busy, mem_req, rf_wr_en, done, err, ea_valid});
    end
    nchk++;
    if (operand !== 16'h0 || ea !== 16'h0 || mem_addr !== 16'h0 || rf_wr_addr !== 3'd0 || rf_wr_data !== 16'h0) begin
      nerr++; $display("FAIL reset_values got op=%h ea=%h addr=%h wa=%0d wd=%h want zeros",
                       operand, ea, mem_addr, rf_wr_addr, rf_wr_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0_byte;
    sregs[3] = 16'h1234;
    do_req(3'd0, 3'd3, 1'b1, 0, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_op !== 16'h0034 || t_lat !== 2 || t_ev !== 1'b0 || t_nreq !== 0) begin
      nerr++; $display("FAIL mode0_byte got op=%h lat=%0d ev=%0b req=%0d want 0034 2 0 0", t_op, t_lat, t_ev, t_nreq);
    end
  endtask

  task automatic test_mode2_byte;
    sregs[2] = 16'h0100; mem[16'h0100] = 16'hABCD;
    do_req(3'd2, 3'd2, 1'b1, 1, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_op !== 16'h00CD || t_wr !== {3'd2, 16'h0101}) begin
      nerr++; $display("FAIL mode2_byte_lo got op=%h wb=%h want 00cd 20101", t_op, t_wr);
    end
    do_req(3'd2, 3'd2, 1'b1, 0, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_op !== 16'h00AB || t_wr !== {3'd2, 16'h0102}) begin
      nerr++; $display("FAIL mode2_byte_hi got op=%h wb=%h want 00ab 20102", t_op, t_wr);
    end
  endtask

  task automatic test_sp_step;
    sregs[6] = 16'h0200;
    do_req(3'd2, 3'd6, 1'b1, 0, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_wr !== {3'd6, 16'h0202}) begin nerr++; $display("FAIL sp_word_step got %h want 60202", t_wr); end
  endtask

  task automatic test_mode7_pc;
    sregs[7] = 16'h1000; mem[16'h1000] = 16'h0010; mem[16'h1012] = 16'h2000; mem[16'h2000] = 16'h5555;
    do_req(3'd7, 3'd7, 1'b0, 0, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_op !== 16'h5555 || t_ea !== 16'h2000 || t_lat !== 8 || t_wr !== {3'd7, 16'h1002}) begin
      nerr++; $display("FAIL mode7_pc got op=%h ea=%h lat=%0d wb=%h want 5555 2000 8 71002", t_op, t_ea, t_lat, t_wr);
    end
  endtask

  task automatic test_odd_fault;
    sregs[1] = 16'h0101;
    do_req(3'd1, 3'd1, 1'b0, 0, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_err !== 1'b1 || t_nreq !== 0) begin nerr++; $display("FAIL odd_fault got err=%0b req=%0d want 1 0", t_err, t_nreq); end
  endtask

  task automatic test_wrap;
    sregs[0] = 16'hFFFE;
    do_req(3'd2, 3'd0, 1'b0, 0, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_wr !== {3'd0, 16'h0000}) begin nerr++; $display("FAIL wrap_inc got %h want 00000", t_wr); end
    sregs[0] = 16'h0000;
    do_req(3'd4, 3'd0, 1'b0, 0, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_ea !== 16'hFFFE || t_wr !== {3'd0, 16'hFFFE}) begin
      nerr++; $display("FAIL wrap_dec got ea=%h wb=%h want fffe 0fffe", t_ea, t_wr);
    end
  endtask

  task automatic test_back_to_back;
    sregs[5] = 16'h0300; mem[16'h0300] = 16'h1111;
    do_req(3'd1, 3'd5, 1'b0, 0, 1'b1, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_op !== 16'h1111 || t_lat !== 4) begin nerr++; $display("FAIL start_while_busy got op=%h lat=%0d want 1111 4", t_op, t_lat); end
    do_req(3'd0, 3'd5, 1'b0, 0, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_op !== 16'h0300) begin nerr++; $display("FAIL back_to_back got op=%h want 0300", t_op); end
  endtask

  task automatic test_reset_mid;
    int n0, ndone, k;
    bit seen;
    sregs[4] = 16'h0300; mem[16'h0300] = 16'h0400; mem[16'h0400] = 16'h7777;
    spurious = 1'b0;
    load_regs();
    n0 = wr_q.size(); wait_cfg = 3;
    @(negedge clk); start = 1'b1; mode = 3'd3; reg_sel = 3'd4; byte_op = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    seen = 0; k = 0;
    while (!seen && k < 60) begin
      @(negedge clk);
      if (mem_req && mem_addr == 16'h0400) seen = 1;
      k++;
    end
    nchk++;
    if (!seen) begin nerr++; $display("FAIL data_phase_req got none want req at 0400"); end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL async_reset got req=%0b busy=%0b want 0 0", mem_req, busy); end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin @(negedge clk); if (done) ndone++; end
    nchk++;
    if (ndone != 0) begin nerr++; $display("FAIL done_after_reset got %0d want 0", ndone); end
    nchk++;
    if (wr_q.size() != n0 + 1) begin nerr++; $display("FAIL wb_after_reset got %0d want %0d", wr_q.size() - n0, 1); end
    sregs[4] = 16'h0302;
    do_req(3'd0, 3'd4, 1'b0, 0, 1'b0, t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    nchk++;
    if (t_op !== 16'h0302) begin nerr++; $display("FAIL restart_after_reset got op=%h want 0302", t_op); end
  endtask

  task automatic test_random;
    logic [15:0] v;
    for (int a = 0; a < 128; a += 2) mem[16'(a)] = 16'($urandom_range(0, 127));
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 8; i++) begin
        v = 16'($urandom_range(0, 63)) << 1;
        if ($urandom_range(0, 7) == 0) v[0] = 1'b1;
        sregs[i] = v;
      end
      spurious = 1'($urandom);
      do_req(3'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b0,
             t_op, t_ea, t_ev, t_err, t_lat, t_nreq, t_wr);
    end
    spurious = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 3'd0; reg_sel = 3'd0; byte_op = 1'b0;
    load_all = 1'b0; wait_cfg = 0; spurious = 1'b0;
    for (int i = 0; i < 8; i++) sregs[i] = 16'h0;
    test_reset();
    test_mode0_byte();
    test_mode2_byte();
    test_sp_step();
    test_mode7_pc();
    test_odd_fault();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
